// File: rtl/rv_enc_pkg.sv
// -----------------------------------------------------------------------------
// rv_enc_pkg
// Shared definitions for the RV32I instruction encoder:
//   - op_e    : command op classes accepted on the command port
//   - fmt_e   : RV32I instruction formats understood by inst_pack
//   - state_e : encoder FSM states
//   - OPC_*   : 7-bit major opcodes
//   - NOP     : canonical ADDI x0,x0,0
// -----------------------------------------------------------------------------
package rv_enc_pkg;

  typedef enum logic [3:0] {
    OP_R      = 4'd0,
    OP_I_ALU  = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_BRANCH = 4'd4,
    OP_LUI    = 4'd5,
    OP_AUIPC  = 4'd6,
    OP_JAL    = 4'd7,
    OP_JALR   = 4'd8,
    OP_LI     = 4'd9,
    OP_CALL   = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_HOLD2 = 1'b1
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when the 32-bit value is the sign extension of its low (msb+1) bits.
  function automatic logic sext_fits(input logic [31:0] value, input int msb);
    logic all_ones;
    logic all_zeros;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= msb) begin
        all_ones  = all_ones & value[i];
        all_zeros = all_zeros & ~value[i];
      end
    end
    return all_ones | all_zeros;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
// Purely combinational bit packer: places already-validated fields into the
// RV32I R/I/S/B/U/J layouts.
//   fmt     in  instruction format
//   opcode  in  7-bit major opcode
//   funct3  in  funct3 field
//   funct7b in  value for inst[30] (R-type and immediate shifts)
//   rd/rs1/rs2 in register indices
//   imm     in  full 32-bit immediate; each format picks its own bits
//   inst    out packed 32-bit instruction word
// -----------------------------------------------------------------------------
module inst_pack
  import rv_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst
);

  logic is_shift_imm;

  // Immediate shifts carry a 5-bit shamt plus the arithmetic bit in inst[30].
  assign is_shift_imm = (opcode == OPC_OP_IMM) && (funct3[1:0] == 2'b01);

  always_comb begin
    inst = NOP;
    case (fmt)
      FMT_R: inst = {1'b0, funct7b, 5'b0, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (is_shift_imm) begin
          inst = {1'b0, funct7b, 5'b0, imm[4:0], rs1, funct3, rd, opcode};
        end else begin
          inst = {imm[11:0], rs1, funct3, rd, opcode};
        end
      end
      FMT_S: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: inst = {imm[31:12], rd, opcode};
      FMT_J: inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: inst = NOP;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Sequential RV32I instruction encoder. Takes field-level commands over a
// valid/ready handshake and emits 32-bit instruction words over a second
// valid/ready handshake, expanding LI and CALL into one or two words.
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o command handshake
//   cmd_op_i                op class (see rv_enc_pkg::op_e)
//   cmd_funct3_i, cmd_alt_i funct3 and inst[30] selector
//   cmd_rd_i/rs1_i/rs2_i    register indices
//   cmd_imm_i               32-bit immediate / value
//   inst_valid_o/inst_ready_i output handshake
//   inst_o, inst_last_o     instruction word and last-word-of-command flag
//   err_o                   one-cycle pulse for a rejected command
// -----------------------------------------------------------------------------
module inst_encoder
  import rv_enc_pkg::*;
#(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [3:0]  cmd_op_i,
  input  logic [2:0]  cmd_funct3_i,
  input  logic        cmd_alt_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [4:0]  cmd_rs1_i,
  input  logic [4:0]  cmd_rs2_i,
  input  logic [31:0] cmd_imm_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic        inst_last_o,
  output logic        err_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_reg, state_next;
  logic [31:0] inst_reg;
  logic        last_reg;
  logic        valid_reg;
  logic        err_reg;
  logic [31:0] hold_reg;

  // ---------------------------------------------------------------------------
  // Field selection for the two packers (index 0: first word, 1: second word)
  // ---------------------------------------------------------------------------
  fmt_e        fmt_sel  [2];
  logic [6:0]  opc_sel  [2];
  logic [2:0]  f3_sel   [2];
  logic        f7b_sel  [2];
  logic [4:0]  rd_sel   [2];
  logic [4:0]  rs1_sel  [2];
  logic [4:0]  rs2_sel  [2];
  logic [31:0] imm_sel  [2];
  logic [31:0] word_sel [2];

  logic        two_word;
  logic        range_bad;
  logic        illegal_op;
  logic        drop_cmd;
  logic        err_cmd;

  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic [19:0] hi;
  logic        lo_zero;
  logic        is_shift;

  logic        accept;
  logic        take;
  logic        load_first;
  logic        load_second;
  logic        drop_valid;

  assign fits12   = sext_fits(cmd_imm_i, 11);
  assign fits13   = sext_fits(cmd_imm_i, 12);
  assign fits21   = sext_fits(cmd_imm_i, 20);
  // (imm + 0x800) >> 12 : round the upper part so the sign-extended low 12
  // bits of the second instruction land exactly on imm.
  assign hi       = cmd_imm_i[31:12] + {19'b0, cmd_imm_i[11]};
  assign lo_zero  = (cmd_imm_i[11:0] == 12'd0);
  assign is_shift = (cmd_funct3_i[1:0] == 2'b01);

  always_comb begin
    fmt_sel[0] = FMT_I;
    opc_sel[0] = OPC_OP_IMM;
    f3_sel[0]  = cmd_funct3_i;
    f7b_sel[0] = 1'b0;
    rd_sel[0]  = cmd_rd_i;
    rs1_sel[0] = cmd_rs1_i;
    rs2_sel[0] = cmd_rs2_i;
    imm_sel[0] = cmd_imm_i;
    // Second word is always an I-type rd,rd,lo op (ADDI for LI, JALR for CALL).
    fmt_sel[1] = FMT_I;
    opc_sel[1] = OPC_OP_IMM;
    f3_sel[1]  = 3'b000;
    f7b_sel[1] = 1'b0;
    rd_sel[1]  = cmd_rd_i;
    rs1_sel[1] = cmd_rd_i;
    rs2_sel[1] = 5'd0;
    imm_sel[1] = cmd_imm_i;
    two_word   = 1'b0;
    range_bad  = 1'b0;
    illegal_op = 1'b0;

    case (cmd_op_i)
      OP_R: begin
        fmt_sel[0] = FMT_R;
        opc_sel[0] = OPC_OP;
        f7b_sel[0] = cmd_alt_i;
      end
      OP_I_ALU: begin
        if (is_shift) begin
          f7b_sel[0] = cmd_alt_i;
          range_bad  = |cmd_imm_i[31:5];
        end else begin
          range_bad  = !fits12;
        end
      end
      OP_LOAD: begin
        opc_sel[0] = OPC_LOAD;
        range_bad  = !fits12 || (cmd_funct3_i == 3'd3) ||
                     (cmd_funct3_i == 3'd6) || (cmd_funct3_i == 3'd7);
      end
      OP_STORE: begin
        fmt_sel[0] = FMT_S;
        opc_sel[0] = OPC_STORE;
        range_bad  = !fits12 || (cmd_funct3_i > 3'd2);
      end
      OP_BRANCH: begin
        fmt_sel[0] = FMT_B;
        opc_sel[0] = OPC_BRANCH;
        range_bad  = !fits13 || cmd_imm_i[0] ||
                     (cmd_funct3_i == 3'd2) || (cmd_funct3_i == 3'd3);
      end
      OP_LUI: begin
        fmt_sel[0] = FMT_U;
        opc_sel[0] = OPC_LUI;
      end
      OP_AUIPC: begin
        fmt_sel[0] = FMT_U;
        opc_sel[0] = OPC_AUIPC;
      end
      OP_JAL: begin
        fmt_sel[0] = FMT_J;
        opc_sel[0] = OPC_JAL;
        range_bad  = !fits21 || cmd_imm_i[0];
      end
      OP_JALR: begin
        opc_sel[0] = OPC_JALR;
        f3_sel[0]  = 3'b000;
        range_bad  = !fits12;
      end
      OP_LI: begin
        f3_sel[0] = 3'b000;
        if (fits12) begin
          rs1_sel[0] = 5'd0;
        end else begin
          fmt_sel[0] = FMT_U;
          opc_sel[0] = OPC_LUI;
          imm_sel[0] = {hi, 12'b0};
          two_word   = !lo_zero;
        end
      end
      OP_CALL: begin
        fmt_sel[0] = FMT_U;
        opc_sel[0] = OPC_AUIPC;
        imm_sel[0] = {hi, 12'b0};
        opc_sel[1] = OPC_JALR;
        two_word   = 1'b1;
      end
      default: illegal_op = 1'b1;
    endcase
  end

  // Without range checking, bad fields are truncated by the packer; an
  // unknown op class still has nothing sensible to emit and is dropped.
  assign drop_cmd = illegal_op || (CHECK_RANGE && range_bad);
  assign err_cmd  = CHECK_RANGE && (illegal_op || range_bad);

  for (genvar gi = 0; gi < 2; gi++) begin : g_pack
    inst_pack u_pack (
      .fmt     (fmt_sel[gi]),
      .opcode  (opc_sel[gi]),
      .funct3  (f3_sel[gi]),
      .funct7b (f7b_sel[gi]),
      .rd      (rd_sel[gi]),
      .rs1     (rs1_sel[gi]),
      .rs2     (rs2_sel[gi]),
      .imm     (imm_sel[gi]),
      .inst    (word_sel[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign cmd_ready_o = rst_ni && (state_reg == S_IDLE) && (!valid_reg || inst_ready_i);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign take        = valid_reg && inst_ready_i;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state and output-register load controls
  always_comb begin
    state_next  = state_reg;
    load_first  = 1'b0;
    load_second = 1'b0;
    drop_valid  = take;
    case (state_reg)
      S_IDLE: begin
        if (accept && !drop_cmd) begin
          load_first = 1'b1;
          if (two_word) begin
            state_next = S_HOLD2;
          end
        end
      end
      S_HOLD2: begin
        if (!valid_reg || inst_ready_i) begin
          load_second = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and pending-word registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_reg  <= NOP;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      hold_reg  <= NOP;
    end else begin
      err_reg <= accept && err_cmd;
      if (load_first) begin
        inst_reg  <= word_sel[0];
        last_reg  <= !two_word;
        valid_reg <= 1'b1;
      end else if (load_second) begin
        inst_reg  <= hold_reg;
        last_reg  <= 1'b1;
        valid_reg <= 1'b1;
      end else if (drop_valid) begin
        valid_reg <= 1'b0;
      end
      if (load_first && two_word) begin
        hold_reg <= word_sel[1];
      end
    end
  end

  assign inst_valid_o = valid_reg;
  assign inst_o       = inst_reg;
  assign inst_last_o  = last_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Self-checking bench for inst_encoder: directed cases from the RV32I encoding
// rules, boundary immediates, backpressure, back-to-back commands, reset in the
// middle of a two-word command, then randomized commands against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [3:0]  cmd_op_i;
  logic [2:0]  cmd_funct3_i;
  logic        cmd_alt_i;
  logic [4:0]  cmd_rd_i;
  logic [4:0]  cmd_rs1_i;
  logic [4:0]  cmd_rs2_i;
  logic [31:0] cmd_imm_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic        inst_last_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  inst_encoder #(.CHECK_RANGE(1'b1)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_funct3_i (cmd_funct3_i),
    .cmd_alt_i    (cmd_alt_i),
    .cmd_rd_i     (cmd_rd_i),
    .cmd_rs1_i    (cmd_rs1_i),
    .cmd_rs2_i    (cmd_rs2_i),
    .cmd_imm_i    (cmd_imm_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_last_o  (inst_last_o),
    .err_o        (err_o)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------ checks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------------------------------------------------- reference model
  function automatic logic [31:0] enc_r(input logic [31:0] f3, alt, rd, rs1, rs2);
    return (alt << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] opc, f3, rd, rs1, imm);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] f3, rs1, rs2, imm);
    return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
           ((imm & 32'h1F) << 7) | 32'h23;
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] f3, rs1, rs2, imm);
    return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
           (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) |
           (((imm >> 11) & 1) << 7) | 32'h63;
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] opc, rd, val);
    return (val & 32'hFFFFF000) | (rd << 7) | opc;
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] rd, imm);
    return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
           (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
  endfunction

  function automatic void model(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, output bit err, output int n,
                                output logic [31:0] w0, output logic [31:0] w1);
    longint s;
    bit in12, inb, inj;
    s    = longint'($signed(imm));
    in12 = (s >= -2048) && (s <= 2047);
    inb  = (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
    inj  = (s >= -(64'sd1 <<< 20)) && (s <= (64'sd1 <<< 20) - 2) && (imm[0] == 1'b0);
    err  = 1'b0;
    n    = 1;
    w0   = 32'h0;
    w1   = 32'h0;
    case (op)
      4'd0: w0 = enc_r(f3, alt, rd, rs1, rs2);
      4'd1: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          err = (imm >> 5) != 0;
          w0  = enc_i(32'h13, f3, rd, rs1, ({31'b0, alt} << 10) | (imm & 32'd31));
        end else begin
          err = !in12;
          w0  = enc_i(32'h13, f3, rd, rs1, imm);
        end
      end
      4'd2: begin
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || !in12;
        w0  = enc_i(32'h03, f3, rd, rs1, imm);
      end
      4'd3: begin
        err = (f3 > 3'd2) || !in12;
        w0  = enc_s(f3, rs1, rs2, imm);
      end
      4'd4: begin
        err = (f3 == 3'd2) || (f3 == 3'd3) || !inb;
        w0  = enc_b(f3, rs1, rs2, imm);
      end
      4'd5: w0 = enc_u(32'h37, rd, imm);
      4'd6: w0 = enc_u(32'h17, rd, imm);
      4'd7: begin
        err = !inj;
        w0  = enc_j(rd, imm);
      end
      4'd8: begin
        err = !in12;
        w0  = enc_i(32'h67, 0, rd, rs1, imm);
      end
      4'd9: begin
        if (in12) begin
          w0 = enc_i(32'h13, 0, rd, 0, imm);
        end else begin
          w0 = enc_u(32'h37, rd, imm + 32'h800);
          if ((imm & 32'hFFF) != 0) begin
            n  = 2;
            w1 = enc_i(32'h13, 0, rd, rd, imm);
          end
        end
      end
      4'd10: begin
        n  = 2;
        w0 = enc_u(32'h17, rd, imm + 32'h800);
        w1 = enc_i(32'h67, 0, rd, rd, imm);
      end
      default: err = 1'b1;
    endcase
    if (err) n = 0;
  endfunction

  // ------------------------------------------------------------- stimulus ops
  task automatic drive(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    cmd_op_i     = op;
    cmd_funct3_i = f3;
    cmd_alt_i    = alt;
    cmd_rd_i     = rd;
    cmd_rs1_i    = rs1;
    cmd_rs2_i    = rs2;
    cmd_imm_i    = imm;
    cmd_valid_i  = 1'b1;
  endtask

  task automatic wait_ready();
    int cnt = 0;
    while (!cmd_ready_o && cnt < 50) begin
      tick();
      cnt++;
    end
    check1("ready_wait", cmd_ready_o, 1'b1);
  endtask

  // Issue one command with the consumer always ready and check every word.
  // When use_gold is set, the first/second words are also checked against
  // hand-encoded constants.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [2:0] f3,
                         input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input bit use_gold,
                         input logic [31:0] g0, input logic [31:0] g1);
    bit          e_err;
    int          n;
    logic [31:0] w[2];
    model(op, f3, alt, rd, rs1, rs2, imm, e_err, n, w[0], w[1]);
    inst_ready_i = 1'b1;
    drive(op, f3, alt, rd, rs1, rs2, imm);
    wait_ready();
    tick();
    cmd_valid_i = 1'b0;
    $display("[TB] %s op=%0d f3=%0d alt=%0d rd=%0d rs1=%0d rs2=%0d imm=%08h words=%0d err=%0d",
             tag, op, f3, alt, rd, rs1, rs2, imm, n, e_err);
    if (e_err) begin
      check1({tag, "_err"}, err_o, 1'b1);
      check1({tag, "_err_novalid"}, inst_valid_o, 1'b0);
      tick();
      check1({tag, "_err_pulse"}, err_o, 1'b0);
      check1({tag, "_err_novalid2"}, inst_valid_o, 1'b0);
    end else begin
      for (int k = 0; k < n; k++) begin
        check1($sformatf("%s_valid%0d", tag, k), inst_valid_o, 1'b1);
        check($sformatf("%s_word%0d", tag, k), inst_o, w[k]);
        if (use_gold) check($sformatf("%s_gold%0d", tag, k), inst_o, (k == 0) ? g0 : g1);
        check1($sformatf("%s_last%0d", tag, k), inst_last_o, k == n - 1);
        check1($sformatf("%s_noerr%0d", tag, k), err_o, 1'b0);
        if (n == 2 && k == 0) check1({tag, "_busy"}, cmd_ready_o, 1'b0);
        tick();
      end
      check1({tag, "_drained"}, inst_valid_o, 1'b0);
    end
  endtask

  // --------------------------------------------------------------- main flow
  initial begin
    logic [31:0] wa, wb, wc0, wc1, dummy;
    bit          e;
    int          n;
    logic [3:0]  rop;
    logic [31:0] rimm;

    cmd_valid_i = 1'b0;
    inst_ready_i = 1'b0;
    drive(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    cmd_valid_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    tick();
    check1("rst_valid", inst_valid_o, 1'b0);
    check("rst_inst", inst_o, 32'h0000_0013);
    check1("rst_last", inst_last_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    check1("rst_ready", cmd_ready_o, 1'b0);
    rst_ni = 1'b1;
    tick();
    check1("post_rst_ready", cmd_ready_o, 1'b1);

    // Directed cases with hand-encoded expectations
    run_cmd("add",   4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 32'h0);
    run_cmd("sub",   4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3, 32'h0);
    run_cmd("li100", 4'd9, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd100, 1'b1, 32'h06400093, 32'h0);
    run_cmd("li_big", 4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 1'b1,
            32'h123462B7, 32'hFFF28293);
    run_cmd("beq8",  4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h00208463, 32'h0);
    run_cmd("beq7",  4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0, 32'h0, 32'h0);

    // Boundary immediates and illegal fields
    run_cmd("li_lo0",    4'd9, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h12345000, 1'b0, 0, 0);
    run_cmd("addi_max",  4'd1, 3'd0, 1'b0, 5'd4, 5'd6, 5'd0, 32'd2047, 1'b0, 0, 0);
    run_cmd("addi_over", 4'd1, 3'd0, 1'b0, 5'd4, 5'd6, 5'd0, 32'd2048, 1'b0, 0, 0);
    run_cmd("addi_min",  4'd1, 3'd0, 1'b0, 5'd4, 5'd6, 5'd0, -32'sd2048, 1'b0, 0, 0);
    run_cmd("srai31",    4'd1, 3'd5, 1'b1, 5'd8, 5'd9, 5'd0, 32'd31, 1'b0, 0, 0);
    run_cmd("slli32",    4'd1, 3'd1, 1'b0, 5'd8, 5'd9, 5'd0, 32'd32, 1'b0, 0, 0);
    run_cmd("b_max",     4'd4, 3'd1, 1'b0, 5'd0, 5'd3, 5'd4, 32'd4094, 1'b0, 0, 0);
    run_cmd("b_min",     4'd4, 3'd5, 1'b0, 5'd0, 5'd3, 5'd4, -32'sd4096, 1'b0, 0, 0);
    run_cmd("b_over",    4'd4, 3'd0, 1'b0, 5'd0, 5'd3, 5'd4, 32'd4096, 1'b0, 0, 0);
    run_cmd("j_max",     4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h000FFFFE, 1'b0, 0, 0);
    run_cmd("j_min",     4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFF00000, 1'b0, 0, 0);
    run_cmd("j_over",    4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b0, 0, 0);
    run_cmd("load_f3",   4'd2, 3'd3, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4, 1'b0, 0, 0);
    run_cmd("store_f3",  4'd3, 3'd3, 1'b0, 5'd0, 5'd2, 5'd3, 32'd4, 1'b0, 0, 0);
    run_cmd("store_ok",  4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd3, -32'sd12, 1'b0, 0, 0);
    run_cmd("bra_f3",    4'd4, 3'd2, 1'b0, 5'd0, 5'd2, 5'd3, 32'd4, 1'b0, 0, 0);
    run_cmd("op12",      4'd12, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 0, 0);

    // Back-to-back: a new command replaces the consumed word with no bubble
    model(4'd0, 3'd4, 1'b0, 5'd10, 5'd11, 5'd12, 32'd0, e, n, wa, dummy);
    model(4'd9, 3'd0, 1'b0, 5'd13, 5'd0, 5'd0, 32'd77, e, n, wb, dummy);
    inst_ready_i = 1'b1;
    drive(4'd0, 3'd4, 1'b0, 5'd10, 5'd11, 5'd12, 32'd0);
    wait_ready();
    tick();
    drive(4'd9, 3'd0, 1'b0, 5'd13, 5'd0, 5'd0, 32'd77);
    check("b2b_first", inst_o, wa);
    check1("b2b_ready", cmd_ready_o, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    $display("[TB] b2b xor then li: %08h %08h", wa, wb);
    check("b2b_second", inst_o, wb);
    check1("b2b_valid", inst_valid_o, 1'b1);
    tick();
    check1("b2b_drained", inst_valid_o, 1'b0);

    // Backpressure during CALL
    model(4'd10, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00012ABC, e, n, wc0, wc1);
    inst_ready_i = 1'b0;
    drive(4'd10, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00012ABC);
    wait_ready();
    tick();
    cmd_valid_i = 1'b0;
    $display("[TB] call under backpressure: %08h %08h", wc0, wc1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d", c), inst_o, wc0);
      check1($sformatf("bp_valid%0d", c), inst_valid_o, 1'b1);
      check1($sformatf("bp_last%0d", c), inst_last_o, 1'b0);
      check1($sformatf("bp_ready%0d", c), cmd_ready_o, 1'b0);
      tick();
    end
    inst_ready_i = 1'b1;
    tick();
    check("bp_second", inst_o, wc1);
    check1("bp_second_last", inst_last_o, 1'b1);
    tick();
    check1("bp_drained", inst_valid_o, 1'b0);

    // Reset asserted while the second LI word is pending
    inst_ready_i = 1'b0;
    drive(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    wait_ready();
    tick();
    cmd_valid_i = 1'b0;
    $display("[TB] reset during HOLD2");
    check1("hold2_valid", inst_valid_o, 1'b1);
    check1("hold2_busy", cmd_ready_o, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check1("mid_rst_valid", inst_valid_o, 1'b0);
    check("mid_rst_inst", inst_o, 32'h0000_0013);
    check1("mid_rst_ready", cmd_ready_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();
    run_cmd("after_rst", 4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 32'h0);

    // Randomized commands against the model
    for (int t = 0; t < 200; t++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      case ($urandom_range(0, 4))
        0: rimm = $urandom;
        1: rimm = $urandom_range(0, 4095) - 2048;
        2: rimm = $urandom_range(0, 16383) - 8192;
        3: rimm = $urandom_range(0, 32'h3FFFFF) - 32'h200000;
        default: rimm = $urandom & 32'hFFFFF000;
      endcase
      if ($urandom_range(0, 1) == 0) rimm[0] = 1'b0;
      run_cmd($sformatf("rnd%0d", t), rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              rimm, 1'b0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential RV32I instruction encoder: the inverse of the core's control decoder. Accepts field-level commands (op class, funct3, alt bit, registers, 32-bit immediate) over a valid/ready handshake and emits 32-bit instruction words over a second valid/ready handshake. Expands the pseudo-ops LI and CALL into one or two words. Sits between the debug/boot sequencer and the instruction-injection port.

## Interface
- CHECK_RANGE, 1: when 1, out-of-range or misaligned immediates and illegal funct3 values raise `err_o` and emit nothing. When 0, fields are truncated silently.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  encoder accepts a command this cycle.
- cmd_op_i  in  4  op class: 0 R, 1 I_ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 LI, 10 CALL; 11-15 illegal.
- cmd_funct3_i  in  3  funct3 for R/I_ALU/LOAD/STORE/BRANCH; ignored otherwise.
- cmd_alt_i  in  1  inst[30] for R (sub/sra) and I_ALU shift-right (srai).
- cmd_rd_i, cmd_rs1_i, cmd_rs2_i  in  5 each  register indices.
- cmd_imm_i  in  32  signed byte offset or value; U-type ops use bits [31:12].
- inst_valid_o  out  1  `inst_o` holds a word.
- inst_ready_i  in  1  consumer takes the word.
- inst_o  out  32  encoded instruction.
- inst_last_o  out  1  word is the final word of its command.
- err_o  out  1  one-cycle pulse: command accepted but rejected.

## Operation
- Formats:
  - R and I_ALU use opcodes 0110011 and 0010011.
  - Shifts (funct3 001/101) encode imm[4:0], with inst[30] taken from `cmd_alt_i`. Other I_ALU ops encode imm[11:0].
  - LOAD 0000011 is I-type. STORE 0100011 is S-type. BRANCH 1100011 is B-type with imm[12:1]. JAL 1101111 is J-type with imm[20:1]. JALR 1100111 is I-type with funct3 000. LUI 0110111 and AUIPC 0010111 are U-type.
- LI rd, imm:
  - If imm fits signed 12 bits, emit one word: ADDI rd,x0,imm.
  - Otherwise hi = (imm + 0x800) >> 12 (mod 2^20) and lo = imm[11:0]. Emit LUI rd,hi, then ADDI rd,rd,lo. If lo == 0, emit LUI alone.
- CALL rd, imm: always two words. First AUIPC rd,hi, then JALR rd,rd,lo, using the same hi/lo split as LI.
- Errors (CHECK_RANGE=1):
  - I/S imm outside [-2048, 2047].
  - Shift imm[31:5] ≠ 0.
  - B imm odd or outside [-4096, 4094].
  - J imm odd or outside [-2^20, 2^20-2].
  - LOAD funct3 ∈ {3,6,7}. STORE funct3 > 2. BRANCH funct3 ∈ {2,3}.
  - Op code 11-15.
  - On any error, the command is consumed, `err_o` pulses in the cycle after acceptance, and no word is produced.
- FSM:
  - IDLE: no pending word.
  - HOLD2: second word stored, waiting to move to the output register.
  - IDLE → HOLD2 on accepting a two-word command.
  - HOLD2 → IDLE when the second word loads into the output register.
- `cmd_ready_o` = rst_ni && state==IDLE && (!inst_valid_o || inst_ready_i).

## Timing
- Output register: a word accepted at edge N is visible at N+1, giving 1-cycle latency. Throughput is one word per cycle under continuous ready.
- While inst_valid_o && !inst_ready_i: inst_o, inst_last_o and inst_valid_o hold stable. A two-word command holds HOLD2 and keeps cmd_ready_o low.
- The second word of LI/CALL appears the cycle after the first word is taken. The first word has inst_last_o=0.
- Simultaneous take and accept: when the output word is consumed while a new command is accepted in the same cycle, the new word replaces it with no bubble.
- Reset values: inst_valid_o=0, inst_o=32'h0000_0013 (NOP), inst_last_o=0, err_o=0, state IDLE, cmd_ready_o=0 while rst_ni is low.
- Reset asserted mid-operation discards the pending word and the output word immediately.

## Structure
- Package rv_enc_pkg holds:
  - The op-class enum.
  - Opcode constants.
  - The format enum (R/I/S/B/U/J).
  - The NOP constant.
- Sub-module inst_pack is purely combinational. Inputs: format, opcode, funct3, funct7 bit, rd/rs1/rs2, imm. Output: the 32-bit word. It is instantiated twice, once for the first word and once for the second word.
- Range checking and the hi/lo split live in inst_encoder.

## Test plan
- add x3,x1,x2 (op 0, f3 0, alt 0) → 0x002081B3, last=1, one cycle after accept. With alt=1 → 0x402081B3.
- LI x1,100 → single word 0x06400093, last=1.
- LI x5,0x12345FFF → 0x123462B7 (last=0), then 0xFFF28293 (last=1). cmd_ready_o stays 0 until the second word is taken.
- BEQ x1,x2,+8 → 0x00208463. BEQ with imm=7 → err_o pulses 1 cycle, inst_valid_o stays 0.
- Backpressure: hold inst_ready_i=0 for 5 cycles during CALL → inst_o stable and no new command accepted. Release → both words delivered in order.
- Drop rst_ni while in HOLD2 → inst_valid_o=0 and inst_o=0x00000013 immediately. After release, the next command encodes correctly.
